time_of_day_clock: RTL and testbench
====================================

Name: time_of_day_clock

Overview:
Generates the 5-bit hour-of-day (0..23) and 6-bit minute values that feed the day/night classifier and the light controller. It counts prescaled second ticks into minutes and hours, wraps at midnight, and accepts a validated synchronous time load from the operator/test interface. It also emits single-cycle hour and midnight event pulses for downstream schedulers.

Parameters:
TICKS_PER_MINUTE, 60, number of secTick pulses per minute increment; legal range 1..255.
RESET_HOUR, 6, hour value loaded on reset; legal range 0..23.
RESET_MINUTE, 0, minute value loaded on reset; legal range 0..59.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
secTick  input  1  one-cycle pulse per simulated second; ignored while low
loadEn  input  1  one-cycle request to load loadHours/loadMinutes
loadHours  input  5  requested hour, valid 0..23
loadMinutes  input  6  requested minute, valid 0..59
hoursOut  output  5  current hour 0..23, registered
minutesOut  output  6  current minute 0..59, registered
hourPulse  output  1  high for exactly one cycle after an hour increment
midnightPulse  output  1  high for exactly one cycle after the 23:59 -> 00:00 wrap
loadError  output  1  high for exactly one cycle after a rejected load

Behaviour:
- Reset, sampled on a clk edge while reset=1: hoursOut=RESET_HOUR, minutesOut=RESET_MINUTE, internal prescaler=0, hourPulse=0, midnightPulse=0, loadError=0. Reset overrides loadEn and secTick in the same cycle.
- Prescaler: an 8-bit counter. It increments on each cycle with secTick=1.
  - When secTick=1 and prescaler=TICKS_PER_MINUTE-1, the prescaler returns to 0 and a minute advance occurs on the same edge.
  - The new minute is visible on the cycle after that edge. Latency from qualifying tick to output is 1 clk.
- Minute advance:
  - minutesOut<59: minutesOut+1.
  - minutesOut=59: minutesOut=0 and an hour advance occurs.
- Hour advance:
  - hoursOut<23: hoursOut+1 and hourPulse=1 next cycle.
  - hoursOut=23: hoursOut=0, hourPulse=1 and midnightPulse=1 next cycle.
- All pulse outputs default to 0 on every cycle without their event. No pulse stretches across cycles.
- Load: evaluated when loadEn=1. Load takes priority over secTick in the same cycle.
  - Valid request (loadHours<=23 and loadMinutes<=59): both values take effect next cycle, prescaler clears to 0, and no hourPulse/midnightPulse is generated for the jump.
  - Invalid request (either field out of range): time and prescaler are unchanged, the coincident secTick is still discarded, and loadError=1 for one cycle.
- Arithmetic: all comparisons are unsigned. hoursOut never exceeds 23 and minutesOut never exceeds 59 under any input sequence.
- Back-to-back: secTick may be high on consecutive cycles. With TICKS_PER_MINUTE=1, every tick advances a minute, and an hour rollover can occur every 60 cycles.
- Reset mid-operation: in-progress prescaler count is discarded and no pulse is emitted for the reset.

Optional Feature:
DAYNIGHT_EDGE_EN: when defined, adds output isDay (1 bit) and output dayNightEdge (1 bit).
- isDay is registered and equals 1 for hours 6..19, otherwise 0. Its reset value is derived from RESET_HOUR.
- dayNightEdge pulses for one cycle whenever isDay changes value, whether from counting or from a valid load.
- When the macro is undefined, these ports and their logic do not exist and all other behaviour is identical.

Test Plan:
- Reset with defaults, hold secTick=0 for 10 cycles -> hoursOut=6, minutesOut=0, all pulses 0.
- TICKS_PER_MINUTE=60, 59 ticks -> minutesOut stays 0; 60th tick -> minutesOut=1 exactly one cycle later.
- Load 5'd22/6'd59, then TICKS_PER_MINUTE ticks -> 23:00 with hourPulse=1 one cycle; repeat from 23:59 -> 00:00 with hourPulse=1 and midnightPulse=1 together.
- Load 5'd24/6'd10 from 06:00 -> time stays 06:00, loadError=1 one cycle; load 5'd3/6'd60 -> same rejection.
- loadEn=1 (12:30) and secTick=1 on the minute boundary in same cycle -> 12:30, prescaler 0, no hourPulse; assert reset=1 during counting -> 06:00 next cycle, pulses 0.
- With DAYNIGHT_EDGE_EN, TICKS_PER_MINUTE=1, load 19:59, one tick -> 20:00, isDay 1->0, dayNightEdge=1 for one cycle.

Source files
------------

// File: rtl/time_of_day_clock_if.sv
// Operator/test-side bundle for time_of_day_clock: tick and load requests in, time and event pulses out.
// The isDay/dayNightEdge pair exists only when DAYNIGHT_EDGE_EN is defined.
interface time_of_day_clock_if;
    logic       secTick;
    logic       loadEn;
    logic [4:0] loadHours;
    logic [5:0] loadMinutes;
    logic [4:0] hoursOut;
    logic [5:0] minutesOut;
    logic       hourPulse;
    logic       midnightPulse;
    logic       loadError;
`ifdef DAYNIGHT_EDGE_EN
    logic       isDay;
    logic       dayNightEdge;

    modport master (
        output secTick, loadEn, loadHours, loadMinutes,
        input  hoursOut, minutesOut, hourPulse, midnightPulse, loadError, isDay, dayNightEdge
    );
    modport slave (
        input  secTick, loadEn, loadHours, loadMinutes,
        output hoursOut, minutesOut, hourPulse, midnightPulse, loadError, isDay, dayNightEdge
    );
`else
    modport master (
        output secTick, loadEn, loadHours, loadMinutes,
        input  hoursOut, minutesOut, hourPulse, midnightPulse, loadError
    );
    modport slave (
        input  secTick, loadEn, loadHours, loadMinutes,
        output hoursOut, minutesOut, hourPulse, midnightPulse, loadError
    );
`endif
endinterface

// File: rtl/time_of_day_clock.sv
// Hour/minute clock counting prescaled secTick, with validated load and hour/midnight pulses; DAYNIGHT_EDGE_EN adds isDay/dayNightEdge.
// Latency 1 clk from qualifying tick or load to outputs; no backpressure, every secTick/loadEn is consumed on its cycle.
module time_of_day_clock #(
    parameter int TICKS_PER_MINUTE = 60,
    parameter int RESET_HOUR       = 6,
    parameter int RESET_MINUTE     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    time_of_day_clock_if.slave    bus
);
    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_MINUTE - 1);
    localparam logic [4:0] RST_HOURS  = 5'(RESET_HOUR);
    localparam logic [5:0] RST_MINS   = 6'(RESET_MINUTE);

    logic [7:0] prescaler, prescaler_nxt;
    logic [4:0] hours, hours_nxt;
    logic [5:0] minutes, minutes_nxt;
    logic       hour_evt, midnight_evt, load_err, load_ok;
    logic       hour_pulse, midnight_pulse, load_error;

    always_comb begin
        prescaler_nxt = prescaler;
        hours_nxt     = hours;
        minutes_nxt   = minutes;
        hour_evt      = 1'b0;
        midnight_evt  = 1'b0;
        load_err      = 1'b0;
        load_ok       = (bus.loadHours <= 5'd23) && (bus.loadMinutes <= 6'd59);
        // A load, accepted or rejected, always swallows a coincident tick.
        if (bus.loadEn) begin
            if (load_ok) begin
                hours_nxt     = bus.loadHours;
                minutes_nxt   = bus.loadMinutes;
                prescaler_nxt = 8'd0;
            end else begin
                load_err = 1'b1;
            end
        end else if (bus.secTick) begin
            if (prescaler == PRESC_LAST) begin
                prescaler_nxt = 8'd0;
                if (minutes == 6'd59) begin
                    minutes_nxt = 6'd0;
                    hour_evt    = 1'b1;
                    if (hours == 5'd23) begin
                        hours_nxt    = 5'd0;
                        midnight_evt = 1'b1;
                    end else begin
                        hours_nxt = hours + 5'd1;
                    end
                end else begin
                    minutes_nxt = minutes + 6'd1;
                end
            end else begin
                prescaler_nxt = prescaler + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler      <= 8'd0;
            hours          <= RST_HOURS;
            minutes        <= RST_MINS;
            hour_pulse     <= 1'b0;
            midnight_pulse <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            prescaler      <= prescaler_nxt;
            hours          <= hours_nxt;
            minutes        <= minutes_nxt;
            hour_pulse     <= hour_evt;
            midnight_pulse <= midnight_evt;
            load_error     <= load_err;
        end
    end

    assign bus.hoursOut      = hours;
    assign bus.minutesOut    = minutes;
    assign bus.hourPulse     = hour_pulse;
    assign bus.midnightPulse = midnight_pulse;
    assign bus.loadError     = load_error;

`ifdef DAYNIGHT_EDGE_EN
    localparam logic RST_DAY = (RESET_HOUR >= 6) && (RESET_HOUR <= 19);

    logic is_day, day_nxt, day_edge;

    assign day_nxt = (hours_nxt >= 5'd6) && (hours_nxt <= 5'd19);

    always_ff @(posedge clk) begin
        if (reset) begin
            is_day   <= RST_DAY;
            day_edge <= 1'b0;
        end else begin
            is_day   <= day_nxt;
            day_edge <= day_nxt ^ is_day;
        end
    end

    assign bus.isDay        = is_day;
    assign bus.dayNightEdge = day_edge;
`endif
endmodule

// File: tb/tb_time_of_day_clock.sv
// Directed bench for time_of_day_clock: a TICKS_PER_MINUTE=60 instance for the main scenarios and a
// TICKS_PER_MINUTE=1 instance for back-to-back ticks and the optional day/night outputs.
module tb_time_of_day_clock;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    time_of_day_clock_if bus_a ();
    time_of_day_clock_if bus_b ();

    time_of_day_clock #(.TICKS_PER_MINUTE(60)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    time_of_day_clock #(.TICKS_PER_MINUTE(1))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.secTick = 1'b1;
            cyc();
        end
        bus_a.secTick = 1'b0;
    endtask

    task automatic load_a(input logic [4:0] h, input logic [5:0] m, input logic tick);
        bus_a.loadEn      = 1'b1;
        bus_a.loadHours   = h;
        bus_a.loadMinutes = m;
        bus_a.secTick     = tick;
        cyc();
        bus_a.loadEn  = 1'b0;
        bus_a.secTick = 1'b0;
    endtask

    task automatic load_b(input logic [4:0] h, input logic [5:0] m);
        bus_b.loadEn      = 1'b1;
        bus_b.loadHours   = h;
        bus_b.loadMinutes = m;
        cyc();
        bus_b.loadEn = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) cyc();
        checks++; if (bus_a.hoursOut !== 5'd6) begin errors++; $display("FAIL reset_hours got=%0d want=6", bus_a.hoursOut); end
        checks++; if (bus_a.minutesOut !== 6'd0) begin errors++; $display("FAIL reset_minutes got=%0d want=0", bus_a.minutesOut); end
        checks++; if ({bus_a.hourPulse, bus_a.midnightPulse, bus_a.loadError} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got=%b want=000", {bus_a.hourPulse, bus_a.midnightPulse, bus_a.loadError}); end
`ifdef DAYNIGHT_EDGE_EN
        checks++; if ({bus_b.isDay, bus_b.dayNightEdge} !== 2'b10) begin
            errors++; $display("FAIL reset_isday got=%b want=10", {bus_b.isDay, bus_b.dayNightEdge}); end
`endif
    endtask

    task automatic test_prescaler();
        ticks_a(59);
        checks++; if (bus_a.minutesOut !== 6'd0) begin errors++; $display("FAIL presc_59 got=%0d want=0", bus_a.minutesOut); end
        ticks_a(1);
        checks++; if (bus_a.minutesOut !== 6'd1) begin errors++; $display("FAIL presc_60 got=%0d want=1", bus_a.minutesOut); end
    endtask

    task automatic test_hour_rollover();
        load_a(5'd22, 6'd59, 1'b0);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse} !== {5'd22, 6'd59, 1'b0}) begin
            errors++; $display("FAIL load_2259 got=%0d:%0d hp=%b want=22:59 hp=0", bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse); end
        ticks_a(60);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse, bus_a.midnightPulse} !== {5'd23, 6'd0, 2'b10}) begin
            errors++; $display("FAIL hour_23 got=%0d:%0d hp=%b mp=%b want=23:0 hp=1 mp=0",
                               bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse, bus_a.midnightPulse); end
        cyc();
        checks++; if (bus_a.hourPulse !== 1'b0) begin errors++; $display("FAIL hour_pulse_width got=%b want=0", bus_a.hourPulse); end
        load_a(5'd23, 6'd59, 1'b0);
        ticks_a(60);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse, bus_a.midnightPulse} !== {5'd0, 6'd0, 2'b11}) begin
            errors++; $display("FAIL midnight got=%0d:%0d hp=%b mp=%b want=0:0 hp=1 mp=1",
                               bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse, bus_a.midnightPulse); end
        cyc();
        checks++; if ({bus_a.hourPulse, bus_a.midnightPulse} !== 2'b00) begin
            errors++; $display("FAIL midnight_width got=%b want=00", {bus_a.hourPulse, bus_a.midnightPulse}); end
    endtask

    task automatic test_load_error();
        do_reset();
        load_a(5'd24, 6'd10, 1'b0);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.loadError} !== {5'd6, 6'd0, 1'b1}) begin
            errors++; $display("FAIL bad_hour got=%0d:%0d le=%b want=6:0 le=1", bus_a.hoursOut, bus_a.minutesOut, bus_a.loadError); end
        cyc();
        checks++; if (bus_a.loadError !== 1'b0) begin errors++; $display("FAIL load_error_width got=%b want=0", bus_a.loadError); end
        load_a(5'd3, 6'd60, 1'b0);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.loadError} !== {5'd6, 6'd0, 1'b1}) begin
            errors++; $display("FAIL bad_minute got=%0d:%0d le=%b want=6:0 le=1", bus_a.hoursOut, bus_a.minutesOut, bus_a.loadError); end
    endtask

    task automatic test_load_priority();
        do_reset();
        load_a(5'd5, 6'd59, 1'b0);
        ticks_a(59);
        load_a(5'd12, 6'd30, 1'b1);
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse} !== {5'd12, 6'd30, 1'b0}) begin
            errors++; $display("FAIL load_vs_tick got=%0d:%0d hp=%b want=12:30 hp=0", bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse); end
        ticks_a(59);
        checks++; if (bus_a.minutesOut !== 6'd30) begin errors++; $display("FAIL load_clears_presc got=%0d want=30", bus_a.minutesOut); end
        ticks_a(1);
        checks++; if (bus_a.minutesOut !== 6'd31) begin errors++; $display("FAIL load_presc_wrap got=%0d want=31", bus_a.minutesOut); end
        ticks_a(59);
        load_a(5'd24, 6'd0, 1'b1);
        checks++; if ({bus_a.minutesOut, bus_a.loadError} !== {6'd31, 1'b1}) begin
            errors++; $display("FAIL bad_load_drops_tick got=%0d le=%b want=31 le=1", bus_a.minutesOut, bus_a.loadError); end
        ticks_a(1);
        checks++; if (bus_a.minutesOut !== 6'd32) begin errors++; $display("FAIL bad_load_keeps_presc got=%0d want=32", bus_a.minutesOut); end
    endtask

    task automatic test_reset_mid();
        ticks_a(30);
        reset = 1'b1;
        bus_a.secTick = 1'b1; bus_a.loadEn = 1'b1; bus_a.loadHours = 5'd12; bus_a.loadMinutes = 6'd0;
        cyc();
        reset = 1'b0; bus_a.secTick = 1'b0; bus_a.loadEn = 1'b0;
        checks++; if ({bus_a.hoursOut, bus_a.minutesOut, bus_a.hourPulse, bus_a.midnightPulse, bus_a.loadError} !== {5'd6, 6'd0, 3'b000}) begin
            errors++; $display("FAIL reset_mid got=%0d:%0d pulses=%b want=6:0 pulses=000", bus_a.hoursOut, bus_a.minutesOut,
                               {bus_a.hourPulse, bus_a.midnightPulse, bus_a.loadError}); end
        ticks_a(59);
        checks++; if (bus_a.minutesOut !== 6'd0) begin errors++; $display("FAIL reset_mid_presc got=%0d want=0", bus_a.minutesOut); end
        ticks_a(1);
        checks++; if (bus_a.minutesOut !== 6'd1) begin errors++; $display("FAIL reset_mid_wrap got=%0d want=1", bus_a.minutesOut); end
    endtask

    task automatic test_back_to_back();
        int hp_count = 0;
        int mp_count = 0;
        int range_bad = 0;
        load_b(5'd22, 6'd58);
        bus_b.secTick = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            cyc();
            if (bus_b.hourPulse) hp_count++;
            if (bus_b.midnightPulse) mp_count++;
            if (bus_b.hoursOut > 5'd23 || bus_b.minutesOut > 6'd59) range_bad++;
            if (i == 2) begin
                checks++; if ({bus_b.hoursOut, bus_b.minutesOut, bus_b.hourPulse} !== {5'd23, 6'd0, 1'b1}) begin
                    errors++; $display("FAIL b2b_hour got=%0d:%0d hp=%b want=23:0 hp=1", bus_b.hoursOut, bus_b.minutesOut, bus_b.hourPulse); end
            end
        end
        bus_b.secTick = 1'b0;
        checks++; if ({bus_b.hoursOut, bus_b.minutesOut, bus_b.midnightPulse} !== {5'd0, 6'd0, 1'b1}) begin
            errors++; $display("FAIL b2b_midnight got=%0d:%0d mp=%b want=0:0 mp=1", bus_b.hoursOut, bus_b.minutesOut, bus_b.midnightPulse); end
        checks++; if (hp_count != 2 || mp_count != 1) begin
            errors++; $display("FAIL b2b_counts got hp=%0d mp=%0d want hp=2 mp=1", hp_count, mp_count); end
        checks++; if (range_bad != 0) begin errors++; $display("FAIL b2b_range got=%0d want=0", range_bad); end
        cyc();
        checks++; if ({bus_b.hourPulse, bus_b.midnightPulse} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle got=%b want=00", {bus_b.hourPulse, bus_b.midnightPulse}); end
    endtask

`ifdef DAYNIGHT_EDGE_EN
    task automatic test_daynight();
        checks++; if (bus_b.isDay !== 1'b0) begin errors++; $display("FAIL dn_midnight got=%b want=0", bus_b.isDay); end
        load_b(5'd19, 6'd59);
        checks++; if ({bus_b.isDay, bus_b.dayNightEdge} !== 2'b11) begin
            errors++; $display("FAIL dn_load got=%b want=11", {bus_b.isDay, bus_b.dayNightEdge}); end
        cyc();
        checks++; if (bus_b.dayNightEdge !== 1'b0) begin errors++; $display("FAIL dn_load_width got=%b want=0", bus_b.dayNightEdge); end
        bus_b.secTick = 1'b1;
        cyc();
        bus_b.secTick = 1'b0;
        checks++; if ({bus_b.hoursOut, bus_b.minutesOut, bus_b.isDay, bus_b.dayNightEdge} !== {5'd20, 6'd0, 2'b01}) begin
            errors++; $display("FAIL dn_dusk got=%0d:%0d isday=%b edge=%b want=20:0 isday=0 edge=1",
                               bus_b.hoursOut, bus_b.minutesOut, bus_b.isDay, bus_b.dayNightEdge); end
        cyc();
        checks++; if (bus_b.dayNightEdge !== 1'b0) begin errors++; $display("FAIL dn_dusk_width got=%b want=0", bus_b.dayNightEdge); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus_a.secTick = 1'b0; bus_a.loadEn = 1'b0; bus_a.loadHours = 5'd0; bus_a.loadMinutes = 6'd0;
        bus_b.secTick = 1'b0; bus_b.loadEn = 1'b0; bus_b.loadHours = 5'd0; bus_b.loadMinutes = 6'd0;
        cyc();
        test_reset();
        test_prescaler();
        test_hour_rollover();
        test_load_error();
        test_load_priority();
        test_reset_mid();
        test_back_to_back();
`ifdef DAYNIGHT_EDGE_EN
        test_daynight();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
